dunpack_32x4: RTL and testbench

- Unpacks 32-bit words into a stream of four bytes; the transmit-side counterpart of the 4x8 byte packer.
- Sits between a 32-bit word source (FIFO or register-bank readout) and an 8-bit byte sink (serializer or link TX).
- Valid/ready handshake on both sides.
- Sustains one byte per clock with no bubble between consecutive words.

---
 rtl/dunpack_32x4_if.sv | 21 ++
 rtl/dunpack_32x4.sv | 66 ++++++
 tb/tb_dunpack_32x4.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/dunpack_32x4_if.sv
// Word-in / byte-out stream bundle for the 32x4 unpacker.
// The slave side is the unpacker; the master side is the surrounding source/sink.
interface dunpack_32x4_if;
    logic [31:0] data_in;
    logic        data_in_valid;
    logic        data_in_ready;
    logic [7:0]  data_out;
    logic        data_out_valid;
    logic        data_out_ready;
    logic        data_out_last;

    modport master (
        output data_in, data_in_valid, data_out_ready,
        input  data_in_ready, data_out, data_out_valid, data_out_last
    );

    modport slave (
        input  data_in, data_in_valid, data_out_ready,
        output data_in_ready, data_out, data_out_valid, data_out_last
    );
endinterface

// File: rtl/dunpack_32x4.sv
// Unpacks 32-bit words into four bytes with valid/ready on both sides.
// The next word is accepted in the same cycle its predecessor's last byte leaves, so the stream has no bubbles.
module dunpack_32x4 #(
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic            sysclk,
    input  logic            sync_n,
    input  logic            clr,
    dunpack_32x4_if.slave   bus
);

    logic [31:0] r_word;
    logic [1:0]  r_idx;
    logic        r_busy;

    logic        w_idx_last;
    logic        w_out_fire;
    logic        w_in_ready;
    logic        w_in_fire;
    logic [1:0]  w_sel;

    assign w_idx_last = (r_idx == 2'd3);
    assign w_out_fire = r_busy & bus.data_out_ready;
    // Combinational through data_out_ready so the last byte and the next word share a cycle
    assign w_in_ready = ~clr & (~r_busy | (w_out_fire & w_idx_last));
    assign w_in_fire  = bus.data_in_valid & w_in_ready;
    assign w_sel      = MSB_FIRST ? (2'd3 - r_idx) : r_idx;

    assign bus.data_in_ready  = w_in_ready;
    assign bus.data_out_valid = r_busy;
    assign bus.data_out_last  = r_busy & w_idx_last;

    always_comb begin
        bus.data_out = r_word[7:0];
        case (w_sel)
            2'd0:    bus.data_out = r_word[7:0];
            2'd1:    bus.data_out = r_word[15:8];
            2'd2:    bus.data_out = r_word[23:16];
            default: bus.data_out = r_word[31:24];
        endcase
    end

    always_ff @(posedge sysclk or negedge sync_n) begin
        if (!sync_n) begin
            r_word <= '0;
            r_idx  <= '0;
            r_busy <= 1'b0;
        end else if (clr) begin
            // Word register is left intact; only the sequencing state is dropped
            r_idx  <= '0;
            r_busy <= 1'b0;
        end else if (w_in_fire) begin
            r_word <= bus.data_in;
            r_idx  <= '0;
            r_busy <= 1'b1;
        end else if (w_out_fire) begin
            if (w_idx_last) begin
                r_idx  <= '0;
                r_busy <= 1'b0;
            end else begin
                r_idx  <= r_idx + 2'd1;
            end
        end
    end

endmodule

// File: tb/tb_dunpack_32x4.sv
// Scoreboard bench for dunpack_32x4: stimulus pushes hand-computed bytes, per-instance monitors pop on each transfer.
// Instance 0 runs MSB_FIRST=1, instance 1 runs MSB_FIRST=0.
module tb_dunpack_32x4;

    logic sysclk;
    logic sync_n;
    logic clr0;
    logic clr1;

    dunpack_32x4_if bus0();
    dunpack_32x4_if bus1();

    dunpack_32x4 #(.MSB_FIRST(1'b1)) u_dut0 (
        .sysclk (sysclk),
        .sync_n (sync_n),
        .clr    (clr0),
        .bus    (bus0.slave)
    );

    dunpack_32x4 #(.MSB_FIRST(1'b0)) u_dut1 (
        .sysclk (sysclk),
        .sync_n (sync_n),
        .clr    (clr1),
        .bus    (bus1.slave)
    );

    initial sysclk = 1'b0;
    always #5 sysclk = ~sysclk;

    int n_total = 0;
    int n_bad   = 0;

    // Entry = {last, byte}
    logic [8:0] exp0[$];
    logic [8:0] exp1[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        n_total++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, want, $time);
        end
    endtask

    task automatic tick();
        @(posedge sysclk);
        #1;
    endtask

    // Offers a word until accepted; expected bytes are queued just before the accepting edge.
    task automatic send(input int sel, input logic [31:0] w,
                        input logic [7:0] b0, input logic [7:0] b1,
                        input logic [7:0] b2, input logic [7:0] b3,
                        output int waits);
        logic rdy;
        waits = 0;
        if (sel == 0) begin
            bus0.data_in = w; bus0.data_in_valid = 1'b1;
        end else begin
            bus1.data_in = w; bus1.data_in_valid = 1'b1;
        end
        #1;
        rdy = (sel == 0) ? bus0.data_in_ready : bus1.data_in_ready;
        while (!rdy && waits < 20) begin
            tick();
            waits++;
            rdy = (sel == 0) ? bus0.data_in_ready : bus1.data_in_ready;
        end
        if (!rdy) begin
            n_total++;
            n_bad++;
            $display("FAIL send_timeout: got ready=0 want ready=1 (sel %0d word %0h)", sel, w);
        end else if (sel == 0) begin
            exp0.push_back({1'b0, b0}); exp0.push_back({1'b0, b1});
            exp0.push_back({1'b0, b2}); exp0.push_back({1'b1, b3});
        end else begin
            exp1.push_back({1'b0, b0}); exp1.push_back({1'b0, b1});
            exp1.push_back({1'b0, b2}); exp1.push_back({1'b1, b3});
        end
        tick();
        if (sel == 0) bus0.data_in_valid = 1'b0;
        else          bus1.data_in_valid = 1'b0;
    endtask

    // Inputs change 1 time unit after posedge, so negedge sees exactly what the next edge will sample
    always @(negedge sysclk) begin
        logic [8:0] e;
        if (sync_n && bus0.data_out_valid && bus0.data_out_ready) begin
            if (exp0.size() == 0) begin
                n_total++;
                n_bad++;
                $display("FAIL mon0_extra: got byte %0h want none", bus0.data_out);
            end else begin
                e = exp0.pop_front();
                check("mon0_byte", {24'd0, bus0.data_out}, {24'd0, e[7:0]});
                check("mon0_last", {31'd0, bus0.data_out_last}, {31'd0, e[8]});
            end
        end
    end

    always @(negedge sysclk) begin
        logic [8:0] e;
        if (sync_n && bus1.data_out_valid && bus1.data_out_ready) begin
            if (exp1.size() == 0) begin
                n_total++;
                n_bad++;
                $display("FAIL mon1_extra: got byte %0h want none", bus1.data_out);
            end else begin
                e = exp1.pop_front();
                check("mon1_byte", {24'd0, bus1.data_out}, {24'd0, e[7:0]});
                check("mon1_last", {31'd0, bus1.data_out_last}, {31'd0, e[8]});
            end
        end
    end

    initial begin
        int w;
        sync_n = 1'b0;
        clr0 = 1'b0;
        clr1 = 1'b0;
        bus0.data_in = '0; bus0.data_in_valid = 1'b0; bus0.data_out_ready = 1'b1;
        bus1.data_in = '0; bus1.data_in_valid = 1'b0; bus1.data_out_ready = 1'b1;

        #2;
        check("rst_valid",    {31'd0, bus0.data_out_valid}, 32'd0);
        check("rst_data",     {24'd0, bus0.data_out},       32'd0);
        check("rst_last",     {31'd0, bus0.data_out_last},  32'd0);
        check("rst_in_ready", {31'd0, bus0.data_in_ready},  32'd1);
        @(posedge sysclk); #1;
        sync_n = 1'b1;
        tick();

        // Single word, sink always ready
        send(0, 32'h11223344, 8'h11, 8'h22, 8'h33, 8'h44, w);
        check("t1_valid_first", {31'd0, bus0.data_out_valid}, 32'd1);
        check("t1_ready_idx0",  {31'd0, bus0.data_in_ready},  32'd0);
        tick();
        check("t1_ready_idx1",  {31'd0, bus0.data_in_ready},  32'd0);
        tick();
        check("t1_ready_idx2",  {31'd0, bus0.data_in_ready},  32'd0);
        tick();
        check("t1_ready_idx3",  {31'd0, bus0.data_in_ready},  32'd1);
        tick();
        check("t1_valid_done",  {31'd0, bus0.data_out_valid}, 32'd0);
        check("t1_q_empty",     exp0.size(), 32'd0);

        // Back-to-back words, no gap
        send(0, 32'hA0A1A2A3, 8'hA0, 8'hA1, 8'hA2, 8'hA3, w);
        send(0, 32'hB0B1B2B3, 8'hB0, 8'hB1, 8'hB2, 8'hB3, w);
        check("t2_b_waits",   w, 32'd3);
        check("t2_q_after_a", exp0.size(), 32'd4);
        repeat (4) tick();
        check("t2_q_empty",   exp0.size(), 32'd0);
        check("t2_valid_done", {31'd0, bus0.data_out_valid}, 32'd0);

        // Sink stall while 0x22 is shown
        send(0, 32'h11223344, 8'h11, 8'h22, 8'h33, 8'h44, w);
        tick();
        bus0.data_out_ready = 1'b0;
        #1;
        check("t3_stall_in_ready", {31'd0, bus0.data_in_ready}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t3_stall_data",  {24'd0, bus0.data_out},       32'h22);
            check("t3_stall_valid", {31'd0, bus0.data_out_valid}, 32'd1);
        end
        bus0.data_out_ready = 1'b1;
        repeat (3) tick();
        check("t3_q_empty", exp0.size(), 32'd0);

        // LSB-first instance
        send(1, 32'hDEADBEEF, 8'hEF, 8'hBE, 8'hAD, 8'hDE, w);
        repeat (4) tick();
        check("t4_q_empty", exp1.size(), 32'd0);
        check("t4_valid_done", {31'd0, bus1.data_out_valid}, 32'd0);

        // clr in the cycle 0x11 transfers, with a new word offered
        send(0, 32'h11223344, 8'h11, 8'h22, 8'h33, 8'h44, w);
        clr0 = 1'b1;
        bus0.data_in = 32'h55667788;
        bus0.data_in_valid = 1'b1;
        #1;
        check("t5_ready_in_clr", {31'd0, bus0.data_in_ready}, 32'd0);
        tick();
        clr0 = 1'b0;
        #1;
        check("t5_valid_dropped", {31'd0, bus0.data_out_valid}, 32'd0);
        check("t5_word_kept",     {24'd0, bus0.data_out},       32'h11);
        check("t5_q_left",        exp0.size(), 32'd3);
        repeat (3) void'(exp0.pop_back());
        send(0, 32'h55667788, 8'h55, 8'h66, 8'h77, 8'h88, w);
        check("t5_accept_waits", w, 32'd0);
        repeat (4) tick();
        check("t5_q_empty", exp0.size(), 32'd0);

        // Async reset after byte 2
        send(0, 32'h11223344, 8'h11, 8'h22, 8'h33, 8'h44, w);
        repeat (2) tick();
        #1;
        sync_n = 1'b0;
        #1;
        check("t6_rst_valid",    {31'd0, bus0.data_out_valid}, 32'd0);
        check("t6_rst_data",     {24'd0, bus0.data_out},       32'd0);
        check("t6_rst_last",     {31'd0, bus0.data_out_last},  32'd0);
        check("t6_q_left",       exp0.size(), 32'd2);
        repeat (2) void'(exp0.pop_back());
        tick();
        sync_n = 1'b1;
        #1;
        check("t6_in_ready", {31'd0, bus0.data_in_ready}, 32'd1);
        send(0, 32'hCAFEF00D, 8'hCA, 8'hFE, 8'hF0, 8'h0D, w);
        check("t6_accept_waits", w, 32'd0);

        // Drain with a bound
        for (int i = 0; i < 50 && (exp0.size() != 0 || exp1.size() != 0); i++) tick();
        check("final_q0_empty", exp0.size(), 32'd0);
        check("final_q1_empty", exp1.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
